spi_slave_gen: RTL and testbench
================================

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
- REQ-001: Parameter DATA_W, default 8, memory data width in bits; legal range 4..32.
- REQ-002: Parameter FRAME_W, default DATA_W+2, receive frame width (2-bit command + data); not overridden by users.
- REQ-003: clk  input  1  single clock; all logic on rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: MOSI  input  1  serial data in, sampled on rising clk.
- REQ-006: SS_n  input  1  slave select, active low; high ends/aborts a frame.
- REQ-007: MISO  output  1  serial data out, MSB first.
- REQ-008: rx_data  output  FRAME_W  received frame {cmd[1:0], payload}.
- REQ-009: rx_valid  output  1  one-cycle pulse qualifying rx_data.
- REQ-010: tx_data  input  DATA_W  read data returned by the memory.
- REQ-011: tx_valid  input  1  qualifies tx_data; one-cycle pulse or level.
- REQ-012: frame_err  output  1  one-cycle pulse on aborted frame (see Configuration).

Function
- REQ-013: FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; registered state, no combinational outputs.
- REQ-014: IDLE -> CHK_CMD when SS_n sampled low; otherwise stay IDLE.
- REQ-015: CHK_CMD samples MOSI: 0 -> WRITE; 1 -> READ_ADD if rd_addr_seen=0, else READ_DATA.
- REQ-016: WRITE/READ_ADD/READ_DATA shift MOSI MSB-first for exactly FRAME_W cycles; bit counter width $clog2(FRAME_W+1).
- REQ-017: Cycle after the FRAME_W-th bit: rx_data updated and rx_valid high for exactly one cycle; rx_data holds until next frame completes.
- REQ-018: READ_ADD completion sets rd_addr_seen; READ_DATA receive completion clears it.
- REQ-019: After READ_DATA receive, wait for tx_valid; first cycle tx_valid=1 captures tx_data; MISO drives bits DATA_W-1..0 over the next DATA_W cycles.
- REQ-020: tx_valid outside READ_DATA wait window ignored; repeat tx_valid during shift-out ignored.
- REQ-021: MISO=0 whenever not shifting out read data; MISO changes only during shift-out.
- REQ-022: After receive/shift-out completes, FSM holds, ignores MOSI until SS_n high, then IDLE.
- REQ-023: SS_n high in any non-IDLE state -> IDLE next cycle; counter cleared, MISO=0, no rx_valid, rx_data unchanged, rd_addr_seen unchanged.
- REQ-024: SS_n rising on same cycle as last receive bit: frame is aborted; no rx_valid.

Reset
- REQ-025: rst_n low asynchronously forces state IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0, rd_addr_seen=0, counters=0.
- REQ-026: Reset mid-frame discards the frame; first cycle after release behaves as IDLE.

Configuration
- REQ-027: Macro SPI_SLAVE_GEN_FRAME_ERR_EN defined: frame_err pulses one cycle after an abort per REQ-023/REQ-024 from CHK_CMD or mid-shift (receive or transmit).
- REQ-028: Macro undefined: frame_err tied 0; no error logic synthesised; all other behaviour identical.

Structure
- REQ-029: Package spi_gen_pkg holds state enum, command encodings (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11), default DATA_W constant.
- REQ-030: Sub-module spi_tx_serializer (load, tx_data, shift enable, MISO, done) implements REQ-019..021.

Verification (DATA_W=8)
- REQ-031: SS_n low, MOSI 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle, 11 cycles after CHK_CMD; MISO stays 0.
- REQ-032: Read-addr frame 1,10_0000_0011 then read-data frame 1,11_0000_0000, tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- REQ-033: Two consecutive read frames with prefix 1 -> first enters READ_ADD, second READ_DATA (rd_addr_seen toggling).
- REQ-034: SS_n high after 5 write bits -> IDLE next cycle, no rx_valid, rx_data unchanged; frame_err=1 one cycle with macro, 0 without.
- REQ-035: rst_n low during READ_DATA shift-out at bit 3 -> MISO=0 immediately, all outputs 0, rd_addr_seen=0.
- REQ-036: SVA: !rst_n |=> MISO==0 && rx_data==0 && !rx_valid; outside shift-out MISO==$past(MISO).

Source files
------------

// File: rtl/spi_gen_pkg.sv
// Shared constants for the generic SPI slave: FSM state codes, command encodings, default width.
package spi_gen_pkg;

  localparam int DEF_DATA_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CHK_CMD   = 3'd1;
  localparam state_t ST_WRITE     = 3'd2;
  localparam state_t ST_READ_ADD  = 3'd3;
  localparam state_t ST_READ_DATA = 3'd4;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first read-data shifter; MISO shows the first bit the cycle after load, then one bit per cycle.
// Latency: DATA_W cycles of data, then done pulses once. Deasserting shift_en aborts and drives MISO low.
// Backpressure: none; load is accepted only while idle, so later loads are dropped.
module spi_tx_serializer
  import spi_gen_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              shift_en,
  output logic              MISO,
  output logic              done
);

  localparam int SCW = $clog2(DATA_W + 1);

  logic              act;
  logic [SCW-1:0]    cnt;
  logic [DATA_W-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      MISO <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!shift_en) begin
        act  <= 1'b0;
        cnt  <= '0;
        MISO <= 1'b0;
      end else if (load && !act) begin
        act  <= 1'b1;
        MISO <= tx_data[DATA_W-1];
        sh   <= tx_data << 1;
        cnt  <= SCW'(DATA_W - 1);
      end else if (act) begin
        if (cnt == '0) begin
          // last bit has been on the wire for a full cycle; return the line to 0
          act  <= 1'b0;
          MISO <= 1'b0;
          done <= 1'b1;
        end else begin
          MISO <= sh[DATA_W-1];
          sh   <= sh << 1;
          cnt  <= cnt - SCW'(1);
        end
      end
    end
  end

  a_miso_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (!act && !$past(act)) |-> (MISO == $past(MISO)));

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front end: 1-bit prefix + FRAME_W-bit frame in, DATA_W read bits out. Macro SPI_SLAVE_GEN_FRAME_ERR_EN enables frame_err.
// Latency: rx_valid the cycle after the last frame bit; MISO starts the cycle after tx_valid is accepted.
// Backpressure: none; SS_n high aborts any frame and returns to IDLE the next cycle.
module spi_slave_gen
  import spi_gen_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FRAME_W = DATA_W + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               MOSI,
  input  logic               SS_n,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               frame_err
);

  localparam int CW = $clog2(FRAME_W + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [FRAME_W-2:0] sh;
  logic               rd_addr_seen;
  logic               tx_wait;
  logic               tx_busy;
  logic               tx_done;
  logic               rx_active;
  logic               last_bit;
  logic               ser_en;
  logic               load;

  assign rx_active = (state == ST_WRITE || state == ST_READ_ADD || state == ST_READ_DATA)
                     && (cnt != CW'(FRAME_W));
  assign last_bit  = (cnt == CW'(FRAME_W - 1));
  assign ser_en    = (state == ST_READ_DATA) && !SS_n;
  assign load      = ser_en && tx_wait && tx_valid && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      sh           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_wait      <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != ST_IDLE && SS_n) begin
        // abort: the frame in flight is dropped, rx_data and rd_addr_seen are kept
        state   <= ST_IDLE;
        cnt     <= '0;
        tx_wait <= 1'b0;
        tx_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!SS_n) state <= ST_CHK_CMD;
          end
          ST_CHK_CMD: begin
            cnt <= '0;
            if (!MOSI)              state <= ST_WRITE;
            else if (!rd_addr_seen) state <= ST_READ_ADD;
            else                    state <= ST_READ_DATA;
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (rx_active) begin
              sh  <= {sh[FRAME_W-3:0], MOSI};
              cnt <= cnt + CW'(1);
              if (last_bit) begin
                rx_data  <= {sh, MOSI};
                rx_valid <= 1'b1;
                if (state == ST_READ_ADD) rd_addr_seen <= 1'b1;
                if (state == ST_READ_DATA) begin
                  rd_addr_seen <= 1'b0;
                  tx_wait      <= 1'b1;
                end
              end
            end
            if (load) begin
              tx_wait <= 1'b0;
              tx_busy <= 1'b1;
            end
            if (tx_done) tx_busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .tx_data  (tx_data),
    .shift_en (ser_en),
    .MISO     (MISO),
    .done     (tx_done)
  );

`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= SS_n && (state == ST_CHK_CMD || rx_active || (tx_busy && !tx_done));
  end
`else
  assign frame_err = 1'b0;
`endif

  a_rst_outputs: assert property (@(posedge clk)
    !rst_n |=> (MISO == 1'b0 && rx_data == '0 && !rx_valid));

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen (DATA_W=8): vector table of full frames plus abort/reset sequences.
module tb_spi_slave_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       frame_err;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SPI_SLAVE_GEN_FRAME_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic       pre;
    logic [9:0] frm;
    logic [7:0] txd;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t tbl[8];

  spi_slave_gen #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MOSI      (MOSI),
    .SS_n      (SS_n),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic pre, input logic [9:0] frm, input int nbits,
                            output logic early_vld, output logic miso_nz);
    early_vld = 1'b0;
    miso_nz   = 1'b0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    MOSI = pre;
    tick();
    miso_nz |= MISO;
    for (int i = 0; i < nbits; i++) begin
      MOSI = frm[9-i];
      early_vld |= rx_valid;
      tick();
      miso_nz |= MISO;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic       ev;
    logic       mz;
    logic [7:0] got;
    send_frame(v.pre, v.frm, 10, ev, mz);
    check("rx_valid_early", 32'(ev), 32'd0);
    check("miso_during_rx", 32'(mz), 32'd0);
    check("rx_valid", 32'(rx_valid), 32'd1);
    check("rx_data", 32'(rx_data), 32'(v.frm));
    tx_data  = v.txd;
    tx_valid = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick();
      got[i] = MISO;
      if (i == 7) check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
    end
    check("miso_byte", 32'(got), 32'(v.exp_miso));
    tick();
    check("miso_after_shift", 32'(MISO), 32'd0);
    tx_valid = 1'b0;
    SS_n     = 1'b1;
    tick();
    check("frame_err_clean", 32'(frame_err), 32'd0);
    tick();
  endtask

  initial begin
    logic ev;
    logic mz;

    tbl[0] = '{1'b0, 10'h0A5, 8'hFF, 8'h00};  // write, tx_valid ignored
    tbl[1] = '{1'b0, 10'h17E, 8'h55, 8'h00};
    tbl[2] = '{1'b1, 10'h203, 8'hAA, 8'h00};  // read address phase
    tbl[3] = '{1'b1, 10'h300, 8'hC3, 8'hC3};  // read data phase
    tbl[4] = '{1'b1, 10'h2FF, 8'h81, 8'h00};
    tbl[5] = '{1'b0, 10'h155, 8'h0F, 8'h00};  // write keeps rd_addr_seen
    tbl[6] = '{1'b1, 10'h3A5, 8'h5A, 8'h5A};
    tbl[7] = '{1'b1, 10'h3FF, 8'h01, 8'h00};

    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();
    tick();
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) run_vec(tbl[k]);

    // abort after 5 write bits
    send_frame(1'b0, 10'h2AA, 5, ev, mz);
    SS_n = 1'b1;
    tick();
    check("abort5_rx_valid", 32'(rx_valid), 32'd0);
    check("abort5_rx_data", 32'(rx_data), 32'h3FF);
    check("abort5_frame_err", 32'(frame_err), 32'(ERR_EXP));
    tick();
    check("abort5_err_one_cycle", 32'(frame_err), 32'd0);
    tick();

    // SS_n rises together with the last bit
    send_frame(1'b0, 10'h2AA, 9, ev, mz);
    MOSI = 1'b0;
    SS_n = 1'b1;
    tick();
    check("abort_last_rx_valid", 32'(rx_valid), 32'd0);
    check("abort_last_rx_data", 32'(rx_data), 32'h3FF);
    check("abort_last_frame_err", 32'(frame_err), 32'(ERR_EXP));
    tick();
    check("abort_last_rx_valid2", 32'(rx_valid), 32'd0);

    // reset during read-data shift-out; rd_addr_seen was still set
    send_frame(1'b1, 10'h3C3, 10, ev, mz);
    check("rd_rx_data", 32'(rx_data), 32'h3C3);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tick();
    tick();
    check("rd_miso_before_rst", 32'(MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(MISO), 32'd0);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    tx_valid = 1'b0;
    SS_n     = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_vec('{1'b1, 10'h201, 8'hFF, 8'h00});  // rd_addr_seen cleared by reset
    run_vec('{1'b1, 10'h396, 8'h96, 8'h96});

    // SS_n high during shift-out
    run_vec('{1'b1, 10'h2FE, 8'h00, 8'h00});
    send_frame(1'b1, 10'h3FF, 10, ev, mz);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tick();
    check("tx_abort_miso_before", 32'(MISO), 32'd1);
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    tick();
    check("tx_abort_miso", 32'(MISO), 32'd0);
    check("tx_abort_frame_err", 32'(frame_err), 32'(ERR_EXP));
    check("tx_abort_rx_valid", 32'(rx_valid), 32'd0);
    tick();
    check("tx_abort_err_one_cycle", 32'(frame_err), 32'd0);
    check("tx_abort_miso_idle", 32'(MISO), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
